fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
- Time-multiplexes the single input anti-alias FIR across the three mic channels.
- Captures each channel's i2s sample, issues the samples to the FIR over an AXI-stream-style handshake in round-robin order, and tags each issue with its channel ID.
- Steers each FIR output back to a per-channel filtered-sample register with a one-cycle valid strobe.
- Sits between the three i2s receivers and downstream consumers (distance calculator, delay line, PDM mux).

Parameters:
- WIDTH, 16, sample width in bits (signed, two's complement).
- NUM_CH, 3, number of mic channels.
- TAG_DEPTH, 8, depth of the in-flight channel-tag FIFO; maximum outstanding FIR samples.
- ISSUE_GAP, 4, minimum idle cycles after each FIR input handshake before the next issue.

Ports:
- clk_in  input  1  system audio clock (98.3 MHz).
- rst_in  input  1  asynchronous active-high reset.
- sample_valid_in  input  NUM_CH  per-channel one-cycle sample strobe from the i2s receivers.
- sample_in  input  NUM_CH*WIDTH  packed samples; ch0 in [WIDTH-1:0].
- fir_s_tvalid  output  1  FIR input valid.
- fir_s_tready  input  1  FIR input ready.
- fir_s_tdata  output  WIDTH  FIR input sample.
- fir_m_tvalid  input  1  FIR output valid.
- fir_m_tdata  input  WIDTH  FIR output sample.
- filtered_out  output  NUM_CH*WIDTH  latest filtered sample per channel, packed like sample_in.
- filtered_valid_out  output  NUM_CH  one-cycle strobe when the matching filtered_out slice updates.
- overrun_out  output  NUM_CH  sticky: an unissued sample was overwritten.
- tag_error_out  output  1  sticky: FIR output arrived while the tag FIFO was empty.
- clear_flags_in  input  1  synchronous clear of overrun_out and tag_error_out.

Behaviour:
- Reset state: all outputs 0, all pending bits 0, tag FIFO empty, round-robin pointer 0, FSM in IDLE.
- Capture stage:
  - sample_valid_in[c] loads hold register c and sets pending[c] on the next edge.
  - If pending[c] is already set, the new value overwrites the held value and overrun_out[c] sets.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - An issue is eligible when any pending bit is set and the tag count is below TAG_DEPTH.
  - Grant the lowest pending index at or after the pointer, wrapping modulo NUM_CH.
  - On grant: copy the hold register to fir_s_tdata, clear pending[grant], set the pointer to grant+1 mod NUM_CH, go to ISSUE.
  - If a new sample for the granted channel arrives in the same cycle, it is captured and pending stays set; no overrun.
- ISSUE:
  - fir_s_tvalid=1, with fir_s_tdata held stable until fir_s_tready=1.
  - On handshake: push the grant ID into the tag FIFO and drop fir_s_tvalid next cycle.
  - Next state is GAP when ISSUE_GAP>0, otherwise IDLE.
- GAP: count ISSUE_GAP cycles, then go to IDLE.
- Latency: fir_s_tvalid rises at the earliest 2 cycles after sample_valid_in, when idle with room in the tag FIFO.
- Return path:
  - On fir_m_tvalid, pop tag t; next cycle filtered_out[t] <= fir_m_tdata and filtered_valid_out[t]=1 for exactly one cycle.
  - Other slices hold their values.
- Tag FIFO empty on fir_m_tvalid: discard the data, set tag_error_out, no strobe.
- Simultaneous push and pop: count unchanged. The full check uses the count after the same-cycle pop.
- clear_flags_in and a new flag event in the same cycle: the flag is set (set wins).
- rst_in asserted mid-ISSUE: fir_s_tvalid drops immediately (asynchronous); tags and pending samples are discarded.
- FIR data is passed through unmodified; no arithmetic on samples.

Test Plan:
- Single channel: ch1 strobe with 0x1234, FIR modelled as 5-cycle pipe of identity -> fir_s_tdata=0x1234 at t+2; filtered_out ch1=0x1234 and filtered_valid_out=3'b010 one cycle only; other slices 0.
- Simultaneous strobes on all channels (0x0001, 0x0002, 0x0003), ISSUE_GAP=4 -> issue order ch0, ch1, ch2, handshakes 5 cycles apart; outputs return to matching slices with no overrun.
- Backpressure: fir_s_tready low 10 cycles during ISSUE -> fir_s_tdata stable; one tag pushed; ch0 re-strobed during the stall -> pending set, overrun_out=0.
- Overrun: two ch2 strobes (0xAAAA then 0xBBBB) while a ch0 issue is stalled -> only 0xBBBB issued for ch2; overrun_out=3'b100 until clear_flags_in.
- Tag full: FIR output withheld, 9 samples offered -> exactly 8 handshakes; 9th issues only after one fir_m_tvalid pop.
- Spurious fir_m_tvalid with empty FIFO -> tag_error_out=1, no strobe. rst_in pulse mid-ISSUE -> all outputs 0 asynchronously; scheduling restarts at ch0.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one FIR between NUM_CH mic channels.
// Samples are captured per channel and issued to the FIR in round-robin order.
// Each issue records its channel ID in a tag FIFO. Each FIR output pops a tag
// and is steered back to that channel's filtered-sample register.
module fir_channel_scheduler #(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 3,
    parameter int TAG_DEPTH = 8,
    parameter int ISSUE_GAP = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_CH-1:0]       sample_valid_in,
    input  logic [NUM_CH*WIDTH-1:0] sample_in,
    output logic                    fir_s_tvalid,
    input  logic                    fir_s_tready,
    output logic [WIDTH-1:0]        fir_s_tdata,
    input  logic                    fir_m_tvalid,
    input  logic [WIDTH-1:0]        fir_m_tdata,
    output logic [NUM_CH*WIDTH-1:0] filtered_out,
    output logic [NUM_CH-1:0]       filtered_valid_out,
    output logic [NUM_CH-1:0]       overrun_out,
    output logic                    tag_error_out,
    input  logic                    clear_flags_in
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [NUM_CH-1:0]         pending_q, pending_d;
    logic signed [WIDTH-1:0]   hold_q [NUM_CH];
    logic [CH_W-1:0]           rr_q, rr_d;
    logic [CH_W-1:0]           grant_q, grant_d;
    logic signed [WIDTH-1:0]   tdata_q, tdata_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [CH_W-1:0]           tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_CH*WIDTH-1:0]   filt_q, filt_d;
    logic [NUM_CH-1:0]         fvalid_q, fvalid_d;
    logic [NUM_CH-1:0]         overrun_q, overrun_d;
    logic                      tagerr_q, tagerr_d;

    logic                      arb_found;
    logic [CH_W-1:0]           arb_idx;
    int                        arb_pos;
    logic                      do_grant;
    logic                      push, pop;
    logic [CNT_W-1:0]          cnt_after_pop;
    logic                      eligible;
    logic [CH_W-1:0]           ret_tag;

    assign push          = (state_q == S_ISSUE) && fir_s_tready;
    assign pop           = fir_m_tvalid && (cnt_q != '0);
    // The room check sees a same-cycle pop so a full FIFO can issue as it drains.
    assign cnt_after_pop = cnt_q - CNT_W'(pop);
    assign eligible      = arb_found && (cnt_after_pop < CNT_W'(TAG_DEPTH));
    assign ret_tag       = tag_mem_q[rd_q];

    // Round-robin search: lowest pending channel at or after the pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_pos = int'(rr_q) + i;
            if (arb_pos >= NUM_CH) arb_pos = arb_pos - NUM_CH;
            if (!arb_found && pending_q[CH_W'(arb_pos)]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(arb_pos);
            end
        end
    end

    // Issue FSM. The final GAP cycle arbitrates too, so handshakes can be ISSUE_GAP+1 apart.
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        do_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (eligible) do_grant = 1'b1;
            end
            S_ISSUE: begin
                if (fir_s_tready) begin
                    if (ISSUE_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    if (eligible) do_grant = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_grant) begin
            state_d = S_ISSUE;
            tdata_d = hold_q[arb_idx];
            grant_d = arb_idx;
            rr_d    = (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // Pending bits and overrun flags; a strobe on the channel being granted is not an overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = clear_flags_in ? '0 : overrun_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (do_grant && (arb_idx == CH_W'(c))) pending_d[c] = 1'b0;
            if (sample_valid_in[c]) begin
                if (pending_q[c] && !(do_grant && (arb_idx == CH_W'(c)))) overrun_d[c] = 1'b1;
                pending_d[c] = 1'b1;
            end
        end
    end

    // Tag FIFO pointers, occupancy, and the return path that steers FIR outputs by tag.
    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        fvalid_d = '0;
        tagerr_d = clear_flags_in ? 1'b0 : tagerr_q;
        if (push) wr_d = (wr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (pop)  rd_d = (rd_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (fir_m_tvalid) begin
            if (pop) begin
                filt_d[int'(ret_tag)*WIDTH +: WIDTH] = fir_m_tdata;
                fvalid_d[ret_tag] = 1'b1;
            end else begin
                tagerr_d = 1'b1;
            end
        end
    end

    // Sample hold registers and tag storage carry data only and need no reset.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (sample_valid_in[c]) hold_q[c] <= sample_in[c*WIDTH +: WIDTH];
        end
        if (push) tag_mem_q[wr_q] <= grant_q;
    end

    // Control and output state; reset discards pending samples and in-flight tags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            tdata_q   <= '0;
            gap_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            filt_q    <= '0;
            fvalid_q  <= '0;
            overrun_q <= '0;
            tagerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            tdata_q   <= tdata_d;
            gap_q     <= gap_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            fvalid_q  <= fvalid_d;
            overrun_q <= overrun_d;
            tagerr_q  <= tagerr_d;
        end
    end

    assign fir_s_tvalid       = (state_q == S_ISSUE);
    assign fir_s_tdata        = tdata_q;
    assign filtered_out       = filt_q;
    assign filtered_valid_out = fvalid_q;
    assign overrun_out        = overrun_q;
    assign tag_error_out      = tagerr_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler with a 5-cycle identity FIR model.
module tb_fir_channel_scheduler;

    typedef struct {
        int          due;
        logic [15:0] d;
    } fir_item_t;

    typedef struct {
        int          ch;
        logic [15:0] d;
    } filt_t;

    logic        clk_in;
    logic        rst_in;
    logic [2:0]  sample_valid_in;
    logic [47:0] sample_in;
    logic        fir_s_tvalid;
    logic        fir_s_tready;
    logic [15:0] fir_s_tdata;
    logic        fir_m_tvalid;
    logic [15:0] fir_m_tdata;
    logic [47:0] filtered_out;
    logic [2:0]  filtered_valid_out;
    logic [2:0]  overrun_out;
    logic        tag_error_out;
    logic        clear_flags_in;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          hs_cyc [0:63];
    logic [15:0] exp_issue_q [$];
    filt_t       exp_filt_q [$];
    fir_item_t   fir_pipe [$];
    fir_item_t   mdl_it;
    filt_t       mon_e;
    logic        fir_hold = 1'b0;
    logic        spur_req = 1'b0;
    logic [15:0] spur_data = 16'h0;

    fir_channel_scheduler #(
        .WIDTH(16), .NUM_CH(3), .TAG_DEPTH(8), .ISSUE_GAP(4)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .sample_valid_in    (sample_valid_in),
        .sample_in          (sample_in),
        .fir_s_tvalid       (fir_s_tvalid),
        .fir_s_tready       (fir_s_tready),
        .fir_s_tdata        (fir_s_tdata),
        .fir_m_tvalid       (fir_m_tvalid),
        .fir_m_tdata        (fir_m_tdata),
        .filtered_out       (filtered_out),
        .filtered_valid_out (filtered_valid_out),
        .overrun_out        (overrun_out),
        .tag_error_out      (tag_error_out),
        .clear_flags_in     (clear_flags_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic strobe(input logic [2:0] m, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2);
        sample_valid_in = m;
        sample_in       = {d2, d1, d0};
        tick(1);
        sample_valid_in = '0;
    endtask

    task automatic expect_s(input int ch, input logic [15:0] d);
        filt_t e;
        e.ch = ch;
        e.d  = d;
        exp_issue_q.push_back(d);
        exp_filt_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_issue_q.size() != 0 || exp_filt_q.size() != 0 || fir_pipe.size() != 0)
               && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 64'(n >= budget), 64'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
    endtask

    // Monitor: compares every FIR input handshake and every filtered strobe to the queues.
    initial forever begin
        @(negedge clk_in);
        if (!rst_in) begin
            if (fir_s_tvalid && fir_s_tready) begin
                hs_cyc[hs_count] = cyc;
                hs_count++;
                mdl_it.due = cyc + 5;
                mdl_it.d   = fir_s_tdata;
                fir_pipe.push_back(mdl_it);
                if (exp_issue_q.size() == 0) chk("issue_unexpected", {48'd0, fir_s_tdata}, 64'hFFFF_FFFF);
                else chk("issue_data", {48'd0, fir_s_tdata}, {48'd0, exp_issue_q.pop_front()});
            end
            if (filtered_valid_out != 3'b000) begin
                if (exp_filt_q.size() == 0) begin
                    chk("strobe_unexpected", {61'd0, filtered_valid_out}, 64'd0);
                end else begin
                    mon_e = exp_filt_q.pop_front();
                    chk("filt_strobe", {61'd0, filtered_valid_out}, 64'(3'b001 << mon_e.ch));
                    chk("filt_data", {48'd0, filtered_out[mon_e.ch*16 +: 16]}, {48'd0, mon_e.d});
                end
            end
        end
    end

    // FIR model: identity with 5-cycle latency, optional output hold and spurious pulses.
    initial begin
        fir_m_tvalid = 1'b0;
        fir_m_tdata  = '0;
        forever begin
            @(posedge clk_in);
            #2;
            fir_m_tvalid = 1'b0;
            if (rst_in) begin
                fir_pipe.delete();
            end else if (spur_req) begin
                fir_m_tvalid = 1'b1;
                fir_m_tdata  = spur_data;
                spur_req     = 1'b0;
            end else if (!fir_hold && fir_pipe.size() != 0 && fir_pipe[0].due <= cyc) begin
                mdl_it       = fir_pipe.pop_front();
                fir_m_tvalid = 1'b1;
                fir_m_tdata  = mdl_it.d;
            end
        end
    end

    initial begin
        int b;
        int r;
        rst_in          = 1'b1;
        sample_valid_in = '0;
        sample_in       = '0;
        fir_s_tready    = 1'b1;
        clear_flags_in  = 1'b0;
        tick(3);
        chk("rst_tvalid", {63'd0, fir_s_tvalid}, 64'd0);
        chk("rst_tdata", {48'd0, fir_s_tdata}, 64'd0);
        chk("rst_filtered", {16'd0, filtered_out}, 64'd0);
        chk("rst_fvalid", {61'd0, filtered_valid_out}, 64'd0);
        chk("rst_overrun", {61'd0, overrun_out}, 64'd0);
        chk("rst_tagerr", {63'd0, tag_error_out}, 64'd0);
        rst_in = 1'b0;

        // Single channel, latency of two cycles from strobe to tvalid.
        expect_s(1, 16'h1234);
        strobe(3'b010, 16'h0, 16'h1234, 16'h0);
        chk("lat_not_early", {63'd0, fir_s_tvalid}, 64'd0);
        tick(1);
        chk("lat_tvalid", {63'd0, fir_s_tvalid}, 64'd1);
        chk("lat_tdata", {48'd0, fir_s_tdata}, 64'h1234);
        wait_drain("drain_single", 40);
        chk("single_filtered", {16'd0, filtered_out}, {16'd0, 16'h0000, 16'h1234, 16'h0000});
        chk("single_overrun", {61'd0, overrun_out}, 64'd0);

        // All channels at once: round-robin order and handshake spacing.
        do_reset();
        b = hs_count;
        expect_s(0, 16'h0001);
        expect_s(1, 16'h0002);
        expect_s(2, 16'h0003);
        strobe(3'b111, 16'h0001, 16'h0002, 16'h0003);
        wait_drain("drain_all3", 80);
        chk("all3_hs_count", 64'(hs_count - b), 64'd3);
        chk("all3_gap01", 64'(hs_cyc[b+1] - hs_cyc[b]), 64'd5);
        chk("all3_gap12", 64'(hs_cyc[b+2] - hs_cyc[b+1]), 64'd5);
        chk("all3_overrun", {61'd0, overrun_out}, 64'd0);
        chk("all3_filtered", {16'd0, filtered_out}, {16'd0, 16'h0003, 16'h0002, 16'h0001});

        // Backpressure: tdata stable while stalled; a re-strobe of ch0 is not an overrun.
        do_reset();
        fir_s_tready = 1'b0;
        expect_s(0, 16'h0A0A);
        strobe(3'b001, 16'h0A0A, 16'h0, 16'h0);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                expect_s(0, 16'h0B0B);
                sample_valid_in = 3'b001;
                sample_in       = {16'h0, 16'h0, 16'h0B0B};
            end
            chk("stall_tvalid", {63'd0, fir_s_tvalid}, 64'd1);
            chk("stall_tdata", {48'd0, fir_s_tdata}, 64'h0A0A);
            tick(1);
            sample_valid_in = '0;
        end
        chk("stall_overrun", {61'd0, overrun_out}, 64'd0);
        fir_s_tready = 1'b1;
        tick(1);
        chk("hs_tvalid_drop", {63'd0, fir_s_tvalid}, 64'd0);
        wait_drain("drain_stall", 60);
        chk("stall_overrun_end", {61'd0, overrun_out}, 64'd0);

        // Overrun: two ch2 strobes while ch0 is stalled; only the second is issued.
        do_reset();
        fir_s_tready = 1'b0;
        expect_s(0, 16'h0C0C);
        strobe(3'b001, 16'h0C0C, 16'h0, 16'h0);
        tick(1);
        strobe(3'b100, 16'h0, 16'h0, 16'hAAAA);
        chk("ovr_first", {61'd0, overrun_out}, 64'd0);
        strobe(3'b100, 16'h0, 16'h0, 16'hBBBB);
        chk("ovr_set", {61'd0, overrun_out}, 64'b100);
        expect_s(2, 16'hBBBB);
        fir_s_tready = 1'b1;
        wait_drain("drain_ovr", 60);
        chk("ovr_sticky", {61'd0, overrun_out}, 64'b100);
        clear_flags_in = 1'b1;
        tick(1);
        clear_flags_in = 1'b0;
        chk("ovr_cleared", {61'd0, overrun_out}, 64'd0);

        // Tag FIFO full: eight outstanding issues, the ninth waits for a pop.
        do_reset();
        fir_hold = 1'b1;
        b = hs_count;
        for (int i = 0; i < 9; i++) begin
            expect_s(i % 3, 16'h0100 + 16'(i));
            case (i % 3)
                0:       strobe(3'b001, 16'h0100 + 16'(i), 16'h0, 16'h0);
                1:       strobe(3'b010, 16'h0, 16'h0100 + 16'(i), 16'h0);
                default: strobe(3'b100, 16'h0, 16'h0, 16'h0100 + 16'(i));
            endcase
            tick(5);
        end
        tick(10);
        chk("full_hs_count", 64'(hs_count - b), 64'd8);
        chk("full_tvalid", {63'd0, fir_s_tvalid}, 64'd0);
        r = cyc;
        fir_hold = 1'b0;
        wait_drain("drain_full", 120);
        chk("full_hs_final", 64'(hs_count - b), 64'd9);
        chk("full_ninth_after_pop", 64'(hs_cyc[b+8] > r), 64'd1);

        // Reset in the middle of a stalled issue.
        fir_s_tready = 1'b0;
        strobe(3'b110, 16'h0, 16'h5555, 16'h6666);
        tick(2);
        chk("pre_rst_tvalid", {63'd0, fir_s_tvalid}, 64'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_tvalid", {63'd0, fir_s_tvalid}, 64'd0);
        chk("arst_tdata", {48'd0, fir_s_tdata}, 64'd0);
        chk("arst_filtered", {16'd0, filtered_out}, 64'd0);
        chk("arst_flags", {60'd0, overrun_out, tag_error_out}, 64'd0);
        tick(1);
        rst_in       = 1'b0;
        fir_s_tready = 1'b1;
        expect_s(0, 16'h0E0E);
        expect_s(2, 16'h0F0F);
        strobe(3'b101, 16'h0E0E, 16'h0, 16'h0F0F);
        wait_drain("drain_restart", 60);
        chk("restart_filtered", {16'd0, filtered_out}, {16'd0, 16'h0F0F, 16'h0000, 16'h0E0E});

        // Spurious FIR output with an empty tag FIFO, then set-wins against clear.
        spur_data = 16'h7777;
        spur_req  = 1'b1;
        tick(1);
        chk("spur_tagerr", {63'd0, tag_error_out}, 64'd1);
        tick(2);
        chk("spur_filtered", {16'd0, filtered_out}, {16'd0, 16'h0F0F, 16'h0000, 16'h0E0E});
        spur_req       = 1'b1;
        clear_flags_in = 1'b1;
        tick(1);
        clear_flags_in = 1'b0;
        chk("tagerr_set_wins", {63'd0, tag_error_out}, 64'd1);
        tick(1);
        clear_flags_in = 1'b1;
        tick(1);
        clear_flags_in = 1'b0;
        chk("tagerr_cleared", {63'd0, tag_error_out}, 64'd0);

        tick(10);
        chk("end_issue_q", 64'(exp_issue_q.size()), 64'd0);
        chk("end_filt_q", 64'(exp_filt_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
